// File: rtl/cube_move_sequencer.sv
// Turns one cube move code at a time into dwell-timed extend/rotate steps for the 4-gripper rig.
// Optional pause input and dwell hold are compiled in with `define CMS_PAUSE_EN.
`timescale 1ns/1ps
module cube_move_sequencer #(
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int unsigned CNT_W        = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move_valid,
   input  logic [3:0] move_code,
   output logic       move_ready,
   output logic [3:0] ext,
   output logic [3:0] rot,
   output logic       busy,
   output logic       done,
   output logic       error
`ifdef CMS_PAUSE_EN
   ,
   input  logic       pause
`endif
);

   typedef enum logic [1:0] {StIdle, StStep, StDone, StErr} state_e;

   localparam logic [1:0]       TypeCcw  = 2'b01;
   localparam logic [1:0]       TypeHalf = 2'b10;
   localparam logic [1:0]       TypeIll  = 2'b11;
   localparam logic [2:0]       LastStep = 3'd5;
   localparam logic [CNT_W-1:0] CntLast  = CNT_W'(DWELL_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       code_q, code_d;
   logic [2:0]       idx_q, idx_d;
   logic             start_q, start_d;
   logic             rep_q, rep_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       ext_q, ext_d;
   logic [3:0]       rot_q, rot_d;

   logic             paused;
   logic             accept;
   logic             step_ccw;
   logic [3:0]       g_mask, o_mask;
   logic [3:0]       first_mask, second_mask;
   logic [2:0]       apply_idx;
   logic [3:0]       step_ext, step_rot;

`ifdef CMS_PAUSE_EN
   assign paused = pause;
`else
   assign paused = 1'b0;
`endif

   assign move_ready = (state_q == StIdle) && !paused;
   assign accept     = move_valid && move_ready;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone) && !paused;
   assign error      = (state_q == StErr);
   assign ext        = ext_q;
   assign rot        = rot_q;

   assign step_ccw = (code_q[3:2] == TypeCcw);
   assign g_mask   = 4'b0001 << code_q[1:0];
   assign o_mask   = code_q[0] ? 4'b0101 : 4'b1010;

   // CW moves clamp the orthogonal pair first; CCW moves lead with gripper g itself.
   assign first_mask  = step_ccw ? g_mask : o_mask;
   assign second_mask = step_ccw ? o_mask : g_mask;

   // Index applied on the next advance: step 0 on first entry and on the HALF rerun.
   assign apply_idx = (start_q || (idx_q == LastStep)) ? 3'd0 : idx_q + 3'd1;

   always_comb begin
      step_ext = ext_q;
      step_rot = rot_q;
      case (apply_idx)
         3'd0:    step_ext = ext_q & ~first_mask;
         3'd1:    step_rot = rot_q | g_mask;
         3'd2:    step_ext = ext_q | first_mask;
         3'd3:    step_ext = ext_q & ~second_mask;
         3'd4:    step_rot = rot_q & ~g_mask;
         3'd5:    step_ext = ext_q | second_mask;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      idx_d   = idx_q;
      start_d = start_q;
      rep_d   = rep_q;
      cnt_d   = cnt_q;
      ext_d   = ext_q;
      rot_d   = rot_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StStep;
               code_d  = move_code;
               start_d = 1'b1;
               rep_d   = (move_code[3:2] == TypeHalf);
               idx_d   = 3'd0;
               cnt_d   = '0;
            end
         end

         StStep: begin
            if (start_q) begin
               // The accept cycle only registers the code; decode happens one edge later.
               if (code_q[3:2] == TypeIll) begin
                  state_d = StErr;
                  start_d = 1'b0;
                  rep_d   = 1'b0;
               end else if (!paused) begin
                  start_d = 1'b0;
                  idx_d   = 3'd0;
                  cnt_d   = '0;
                  ext_d   = step_ext;
                  rot_d   = step_rot;
               end
            end else if (!paused) begin
               if (cnt_q == CntLast) begin
                  cnt_d = '0;
                  if (idx_q == LastStep && !rep_q) begin
                     state_d = StDone;
                  end else begin
                     if (idx_q == LastStep) begin
                        rep_d = 1'b0;
                     end
                     idx_d = apply_idx;
                     ext_d = step_ext;
                     rot_d = step_rot;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         StDone: begin
            if (!paused) begin
               state_d = StIdle;
            end
         end

         StErr: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         code_q  <= 4'b0000;
         idx_q   <= 3'd0;
         start_q <= 1'b0;
         rep_q   <= 1'b0;
         cnt_q   <= '0;
         ext_q   <= 4'b1111;
         rot_q   <= 4'b0000;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         start_q <= start_d;
         rep_q   <= rep_d;
         cnt_q   <= cnt_d;
         ext_q   <= ext_d;
         rot_q   <= rot_d;
      end
   end

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Scoreboard bench for cube_move_sequencer: each accepted move queues its expected per-cycle outputs.
`timescale 1ns/1ps
module tb_cube_move_sequencer;

   localparam int unsigned DW = 4;

   localparam logic [3:0] F_IDLE = 4'b1000;  // {ready, busy, done, error}
   localparam logic [3:0] F_BUSY = 4'b0100;
   localparam logic [3:0] F_DONE = 4'b0110;
   localparam logic [3:0] F_ERR  = 4'b0101;

   typedef struct packed {
      logic [3:0] ext;
      logic [3:0] rot;
      logic [3:0] flags;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       move_valid;
   logic [3:0] move_code;
   logic       move_ready;
   logic [3:0] ext;
   logic [3:0] rot;
   logic       busy;
   logic       done;
   logic       error;
`ifdef CMS_PAUSE_EN
   logic       pause;
`endif

   obs_t       sb[$];
   logic [3:0] m_ext, m_rot;
   int         n_checks;
   int         n_pass;
   int         cyc;

   cube_move_sequencer #(
      .DWELL_CYCLES(DW),
      .CNT_W       (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .move_valid(move_valid),
      .move_code (move_code),
      .move_ready(move_ready),
      .ext       (ext),
      .rot       (rot),
      .busy      (busy),
      .done      (done),
      .error     (error)
`ifdef CMS_PAUSE_EN
      ,
      .pause     (pause)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic void push_obs(input logic [3:0] flags);
      obs_t o;
      o.ext   = m_ext;
      o.rot   = m_rot;
      o.flags = flags;
      sb.push_back(o);
   endfunction

   // {target is gripper g (else orthogonal pair), field is rot (else ext), new bit value}
   function automatic logic [2:0] step_entry(input bit ccw, input int s);
      case (s)
         0:       return ccw ? 3'b100 : 3'b000;
         1:       return 3'b111;
         2:       return ccw ? 3'b101 : 3'b001;
         3:       return ccw ? 3'b000 : 3'b100;
         4:       return 3'b110;
         default: return ccw ? 3'b001 : 3'b101;
      endcase
   endfunction

   // Expected observations from the accept cycle through the first idle cycle afterwards.
   function automatic void push_move(input logic [3:0] code, input int pause_cycles);
      int         g;
      int         nsteps;
      bit         ccw;
      logic [3:0] one;
      logic [3:0] gm, om, mask;
      logic [2:0] e;
      g   = int'(code[1:0]);
      one = 4'b0001;
      gm  = one << g;
      om  = (one << ((g + 1) % 4)) | (one << ((g + 3) % 4));
      push_obs(F_BUSY);
      if (code[3:2] == 2'b11) begin
         push_obs(F_ERR);
         push_obs(F_IDLE);
         return;
      end
      ccw    = (code[3:2] == 2'b01);
      nsteps = (code[3:2] == 2'b10) ? 12 : 6;
      for (int s = 0; s < nsteps; s++) begin
         e    = step_entry(ccw, s % 6);
         mask = e[2] ? gm : om;
         if (e[1]) m_rot = e[0] ? (m_rot | mask) : (m_rot & ~mask);
         else      m_ext = e[0] ? (m_ext | mask) : (m_ext & ~mask);
         for (int c = 0; c < int'(DW) + ((s == 1) ? pause_cycles : 0); c++) push_obs(F_BUSY);
      end
      push_obs(F_DONE);
      push_obs(F_IDLE);
   endfunction

   // Drive a code, wait for acceptance, then queue its expected behaviour.
   task automatic send(input logic [3:0] code, input bit hold, input int pause_cycles);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      move_valid = 1'b1;
      move_code  = code;
      for (int n = 0; n < 200; n++) begin
         if (move_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq($sformatf("accept_%0h", code), 32'(ok), 32'd1);
      if (ok) push_move(code, pause_cycles);
      @(posedge clk);
      #2;
      if (!hold) begin
         move_valid = 1'b0;
         move_code  = 4'hC;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && sb.size() > 0; n++) @(negedge clk);
      check_eq("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      obs_t e;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("c%0d.ext", cyc), 32'(ext), 32'(e.ext));
            check_eq($sformatf("c%0d.rot", cyc), 32'(rot), 32'(e.rot));
            check_eq($sformatf("c%0d.rdy_busy_done_err", cyc),
                     32'({move_ready, busy, done, error}), 32'(e.flags));
         end
      end
   end

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      move_valid = 1'b0;
      move_code  = 4'h0;
      m_ext      = 4'b1111;
      m_rot      = 4'b0000;
`ifdef CMS_PAUSE_EN
      pause      = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      push_obs(F_IDLE);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of step 2, then a clean run of the same code.
      send(4'h0, 1'b0, 0);
      repeat (2 * DW + 3) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      m_ext = 4'b1111;
      m_rot = 4'b0000;
      push_obs(F_IDLE);
      @(negedge clk);
      rst = 1'b0;
      send(4'h0, 1'b0, 0);
      drain();

      send(4'h1, 1'b0, 0);  // CW left
      drain();
      send(4'h4, 1'b0, 0);  // CCW top
      drain();
      send(4'hB, 1'b0, 0);  // HALF right
      drain();
      send(4'hC, 1'b0, 0);  // illegal
      drain();

      // Back-pressure: valid stays high with a different code during the first move.
      send(4'h2, 1'b1, 0);
      send(4'h7, 1'b0, 0);
      drain();

`ifdef CMS_PAUSE_EN
      send(4'h5, 1'b0, 10);
      repeat (DW + 3) @(negedge clk);
      pause = 1'b1;
      repeat (10) @(negedge clk);
      pause = 1'b0;
      drain();
`endif

      @(negedge clk);
      check_eq("final_ext", 32'(ext), 32'hF);
      check_eq("final_rot", 32'(rot), 32'h0);
      check_eq("final_busy", 32'(busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
